muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, next to the ALU.
- Consumes the same SrcA/SrcB operands the ALU receives.
- Its result is muxed with ALUResult ahead of the EX/MEM register. Hazard control uses its busy signal to stall the pipeline until done.
- Radix-2 algorithm: one bit per cycle, constant latency for every op.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_sign_fix.sv | 62 ++++++
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_DATA_WIDTH = 32;
  // Cycles from the accepting edge to the done cycle.
  localparam int MULDIV_LATENCY    = MULDIV_DATA_WIDTH + 2;

  // funct3 encodings of the M extension.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // True when the op interprets SrcA as a two's complement value.
  function automatic logic op_signed_a(input muldiv_op_e op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // True when the op interprets SrcB as a two's complement value.
  function automatic logic op_signed_b(input muldiv_op_e op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational final-word formation: sign restoration of the magnitude
// results plus the divide-by-zero and signed-overflow special cases.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  muldiv_op_e                  i_op,
  input  logic [2*DATA_WIDTH-1:0]     i_prod_mag,
  input  logic [DATA_WIDTH-1:0]       i_quo_mag,
  input  logic [DATA_WIDTH-1:0]       i_rem_mag,
  input  logic [DATA_WIDTH-1:0]       i_src_a,
  input  logic                        i_sign_a,
  input  logic                        i_sign_b,
  input  logic                        i_div_zero,
  input  logic                        i_overflow,
  output logic [DATA_WIDTH-1:0]       o_result
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                  w_res_neg;
  logic [PW-1:0]         w_prod_fix;
  logic [DATA_WIDTH-1:0] w_quo_fix;
  logic [DATA_WIDTH-1:0] w_rem_fix;

  // Product and quotient are negative when exactly one operand is;
  // the remainder follows the dividend.
  assign w_res_neg  = i_sign_a ^ i_sign_b;
  assign w_prod_fix = w_res_neg ? (~i_prod_mag + PW'(1)) : i_prod_mag;
  assign w_quo_fix  = w_res_neg ? (~i_quo_mag + DATA_WIDTH'(1)) : i_quo_mag;
  assign w_rem_fix  = i_sign_a ? (~i_rem_mag + DATA_WIDTH'(1)) : i_rem_mag;

  // Select the architectural result word for the op.
  always_comb begin
    o_result = {DATA_WIDTH{1'b0}};
    case (i_op)
      OP_MUL: o_result = w_prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: o_result = w_prod_fix[PW-1:DATA_WIDTH];
      OP_DIV, OP_DIVU: begin
        if (i_div_zero) begin
          o_result = {DATA_WIDTH{1'b1}};
        end else if (i_overflow) begin
          o_result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
          o_result = w_quo_fix;
        end
      end
      OP_REM, OP_REMU: begin
        if (i_div_zero) begin
          o_result = i_src_a;
        end else if (i_overflow) begin
          o_result = {DATA_WIDTH{1'b0}};
        end else begin
          o_result = w_rem_fix;
        end
      end
      default: o_result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Fixed latency for every op: accept, DATA_WIDTH CALC cycles, FIX, DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_LENGTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [OP_LENGTH-1:0]  Op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int PW    = 2 * DATA_WIDTH;

  muldiv_state_e         r_state;
  muldiv_state_e         w_next_state;
  muldiv_op_e            r_op;
  logic [DATA_WIDTH-1:0] r_src_a;
  logic [DATA_WIDTH-1:0] r_a_mag;
  logic [DATA_WIDTH-1:0] r_b_mag;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_div_zero;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_count;
  logic [PW-1:0]         r_prod;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_busy;
  logic                  r_done;

  muldiv_op_e            w_op_in;
  logic                  w_sign_a_in;
  logic                  w_sign_b_in;
  logic [DATA_WIDTH-1:0] w_a_mag_in;
  logic [DATA_WIDTH-1:0] w_b_mag_in;
  logic                  w_div_zero_in;
  logic                  w_overflow_in;
  logic                  w_accept;
  logic [DATA_WIDTH:0]   w_mul_sum;
  logic [PW-1:0]         w_prod_next;
  logic [DATA_WIDTH:0]   w_rem_shift;
  logic [DATA_WIDTH:0]   w_rem_diff;
  logic                  w_rem_ge;
  logic [DATA_WIDTH-1:0] w_fix_result;

  // Operand decode at acceptance: signedness, magnitudes, special cases.
  assign w_op_in       = muldiv_op_e'(Op);
  assign w_sign_a_in   = op_signed_a(w_op_in) & SrcA[DATA_WIDTH-1];
  assign w_sign_b_in   = op_signed_b(w_op_in) & SrcB[DATA_WIDTH-1];
  assign w_a_mag_in    = w_sign_a_in ? (~SrcA + DATA_WIDTH'(1)) : SrcA;
  assign w_b_mag_in    = w_sign_b_in ? (~SrcB + DATA_WIDTH'(1)) : SrcB;
  assign w_div_zero_in = (SrcB == {DATA_WIDTH{1'b0}});
  assign w_overflow_in = ((w_op_in == OP_DIV) || (w_op_in == OP_REM)) &&
                         (SrcA == {1'b1, {(DATA_WIDTH-1){1'b0}}}) &&
                         (SrcB == {DATA_WIDTH{1'b1}});
  assign w_accept      = (r_state == ST_IDLE) && start && !flush;

  // Shift-add multiply: add the multiplicand into the high half when the
  // current multiplier bit (LSB) is set, then shift the whole register right.
  assign w_mul_sum   = {1'b0, r_prod[PW-1:DATA_WIDTH]} + {1'b0, r_a_mag};
  assign w_prod_next = r_prod[0] ? {w_mul_sum, r_prod[DATA_WIDTH-1:1]}
                                 : {1'b0, r_prod[PW-1:1]};

  // Restoring divide: the shifted partial remainder is one bit wider than
  // the operands so the trial subtraction's borrow lands in the top bit.
  assign w_rem_shift = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_b_mag};
  assign w_rem_ge    = ~w_rem_diff[DATA_WIDTH];

  muldiv_sign_fix #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sign_fix (
    .i_op       (r_op),
    .i_prod_mag (r_prod),
    .i_quo_mag  (r_quo),
    .i_rem_mag  (r_rem),
    .i_src_a    (r_src_a),
    .i_sign_a   (r_sign_a),
    .i_sign_b   (r_sign_b),
    .i_div_zero (r_div_zero),
    .i_overflow (r_overflow),
    .o_result   (w_fix_result)
  );

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_CALC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_count == {CNT_W{1'b0}}) begin
          w_next_state = ST_FIX;
        end else begin
          w_next_state = ST_CALC;
        end
      end
      ST_FIX:  w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) begin
      w_next_state = ST_IDLE;
    end else begin
      w_next_state = w_next_state;
    end
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Operand capture, iteration datapath, iteration counter and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op       <= OP_MUL;
      r_src_a    <= {DATA_WIDTH{1'b0}};
      r_a_mag    <= {DATA_WIDTH{1'b0}};
      r_b_mag    <= {DATA_WIDTH{1'b0}};
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= {CNT_W{1'b0}};
      r_prod     <= {PW{1'b0}};
      r_rem      <= {DATA_WIDTH{1'b0}};
      r_quo      <= {DATA_WIDTH{1'b0}};
      r_result   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= w_op_in;
            r_src_a    <= SrcA;
            r_a_mag    <= w_a_mag_in;
            r_b_mag    <= w_b_mag_in;
            r_sign_a   <= w_sign_a_in;
            r_sign_b   <= w_sign_b_in;
            r_div_zero <= w_div_zero_in;
            r_overflow <= w_overflow_in;
            r_count    <= CNT_W'(DATA_WIDTH - 1);
            r_prod     <= {{DATA_WIDTH{1'b0}}, w_b_mag_in};
            r_rem      <= {DATA_WIDTH{1'b0}};
            r_quo      <= w_a_mag_in;
          end
        end
        ST_CALC: begin
          // Both engines step every cycle; the FIX stage picks the one the op needs.
          r_prod <= w_prod_next;
          r_rem  <= w_rem_ge ? w_rem_diff[DATA_WIDTH-1:0] : w_rem_shift[DATA_WIDTH-1:0];
          r_quo  <= {r_quo[DATA_WIDTH-2:0], w_rem_ge};
          if (r_count != {CNT_W{1'b0}}) begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!flush) begin
            r_result <= w_fix_result;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus hand-written
// sequences for start-while-busy, flush and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_FLUSH = 2;
  localparam int EV_RESET = 3;
  localparam int NVEC     = 19;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  Op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  muldiv_unit #(
    .DATA_WIDTH (32),
    .OP_LENGTH  (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Op     (Op),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Launch one op and follow it cycle by cycle (sampled on negedges).
  // Optionally injects a start/flush/reset pulse after sample ev_cyc.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit skip_wait, input int ev_cyc, input int ev_kind,
                        output int lat, output int busy_cnt, output logic [31:0] res,
                        output logic post_busy, output logic post_done,
                        output logic [31:0] post_res);
    if (!skip_wait) @(negedge clk);
    Op = op; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cnt = 0; res = 32'h0;
    post_busy = 1'b0; post_done = 1'b0; post_res = 32'h0;
    for (int n = 1; n <= MULDIV_LATENCY + 6; n++) begin
      @(negedge clk);
      if (ev_kind != EV_NONE && n == ev_cyc + 1) begin
        start = 1'b0; flush = 1'b0; reset = 1'b0;
        if (ev_kind == EV_FLUSH || ev_kind == EV_RESET) begin
          post_busy = busy; post_done = done; post_res = Result;
          break;
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = n; res = Result;
        break;
      end
      if (n == ev_cyc) begin
        case (ev_kind)
          EV_START: begin start = 1'b1; Op = 3'b100; SrcA = 32'd9; SrcB = 32'd2; end
          EV_FLUSH: flush = 1'b1;
          EV_RESET: reset = 1'b1;
          default:  ;
        endcase
      end
    end
  endtask

  initial begin
    int          lat;
    int          bc;
    logic [31:0] res;
    logic        pb;
    logic        pd;
    logic [31:0] pr;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    Op = 3'b000; SrcA = 32'h0; SrcB = 32'h0;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB}; // MUL 7*-3
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000}; // MULH
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}; // MULHU
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}; // MULHSU
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD}; // DIV -7/2
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF}; // REM -7%2
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14};       // DIVU
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2};        // REMU
    vecs[8]  = '{3'b101, 32'h00001234, 32'h0,        32'hFFFFFFFF}; // DIVU /0
    vecs[9]  = '{3'b110, 32'h00001234, 32'h0,        32'h00001234}; // REM /0
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000}; // DIV overflow
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}; // REM overflow
    vecs[12] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780}; // MUL low word
    vecs[13] = '{3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF}; // MULH -1*2
    vecs[14] = '{3'b011, 32'h80000000, 32'd4,        32'h00000002}; // MULHU 2^33
    vecs[15] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD}; // DIV 7/-2
    vecs[16] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001}; // REM 7%-2
    vecs[17] = '{3'b101, 32'hFFFFFFF9, 32'h00000010, 32'h0FFFFFFF}; // DIVU large
    vecs[18] = '{3'b100, 32'h80000000, 32'h0,        32'hFFFFFFFF}; // DIV /0 signed

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_result", Result, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_result", Result, 32'h0);

    // Table: each op starts in the cycle right after the previous done.
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 0, EV_NONE, lat, bc, res, pb, pd, pr);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(MULDIV_LATENCY));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(MULDIV_LATENCY));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
      check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'h0);
      check($sformatf("vec%0d_result_held", i), Result, vecs[i].exp);
    end

    // Start with new operands while busy is ignored.
    run_op(3'b000, 32'd3, 32'd5, 1'b1, 10, EV_START, lat, bc, res, pb, pd, pr);
    check("ign_start_result", res, 32'd15);
    check("ign_start_latency", 32'(lat), 32'(MULDIV_LATENCY));
    @(negedge clk);

    // Flush mid-operation: no done, Result kept, restart next cycle.
    run_op(3'b000, 32'd6, 32'd7, 1'b1, 20, EV_FLUSH, lat, bc, res, pb, pd, pr);
    check("flush_no_done_seen", 32'(lat), 32'h0);
    check("flush_busy", 32'(pb), 32'h0);
    check("flush_done", 32'(pd), 32'h0);
    check("flush_result_kept", pr, 32'd15);
    run_op(3'b101, 32'd100, 32'd7, 1'b1, 0, EV_NONE, lat, bc, res, pb, pd, pr);
    check("post_flush_result", res, 32'd14);
    check("post_flush_latency", 32'(lat), 32'(MULDIV_LATENCY));
    @(negedge clk);

    // Reset in the middle of a DIV.
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, 15, EV_RESET, lat, bc, res, pb, pd, pr);
    check("midrst_busy", 32'(pb), 32'h0);
    check("midrst_done", 32'(pd), 32'h0);
    check("midrst_result", pr, 32'h0);
    run_op(3'b111, 32'd100, 32'd7, 1'b1, 0, EV_NONE, lat, bc, res, pb, pd, pr);
    check("post_rst_result", res, 32'd2);
    check("post_rst_latency", 32'(lat), 32'(MULDIV_LATENCY));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
